calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 17 +
 rtl/calc_operand_reg.sv | 45 ++++
 rtl/calc_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, operator codes and default width for the calculator sequencer.
package calc_pkg;

    localparam int W_DEF = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_EXEC = 3'd2,
        S_RES  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/calc_operand_reg.sv
// calc_operand_reg: hex-digit shift-entry operand register with digit count, parallel load and clear.
module calc_operand_reg
    import calc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = $clog2(W / 4 + 1)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [W-1:0]  load_val_i,
    input  logic [CW-1:0] load_cnt_i,
    input  logic          shift_i,
    input  logic [3:0]    key_i,
    output logic [W-1:0]  val_o
);

    localparam int N = W / 4;

    logic [W-1:0]  val_q, val_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          take;

    // Clear beats load beats digit shift; digits beyond a full register are dropped.
    always_comb begin
        take  = shift_i && (cnt_q < CW'(N));
        val_d = clr_i ? '0 : load_i ? load_val_i : take ? ((val_q << 4) | W'(key_i)) : val_q;
        cnt_d = clr_i ? '0 : load_i ? load_cnt_i : take ? cnt_q + CW'(1) : cnt_q;
    end

    // Operand value and digit count registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator control FSM driving an external add/sub ALU.
// Optional memory register enabled by defining CALC_MEM_EN.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         op_add,
    input  logic         op_sub,
    input  logic         eq,
    input  logic         clr,
    input  logic         mem_save,
    input  logic         mem_recall,
    input  logic [W-1:0] alu_q,
    input  logic         alu_ovf,
    input  logic         alu_done,
    output logic         alu_start,
    output logic         alu_op,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         disp_sel,
    output logic         err,
    output logic [2:0]   state
);

    localparam int CW = $clog2(W / 4 + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(W / 4);

    state_t         state_q;
    logic           alu_start_q, alu_op_q, overflow_q, err_q, disp_sel_q;
    logic [W-1:0]   result_q, mem_val;
    logic [TW-1:0]  tmo_q;
    logic           hi, e_eq, e_op, e_key, e_mr, in_a, in_b, in_res;
    logic           a_load, b_load, a_shift, b_shift;
    logic [W-1:0]   a_val, b_val;
    logic [CW-1:0]  a_cnt, b_cnt;

`ifdef CALC_MEM_EN
    logic           e_ms;
    logic [W-1:0]   mem_q;

    // Memory captures the shown result on request and survives clr.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            mem_q <= '0;
        else if (in_res && e_ms)
            mem_q <= result_q;
    end

    assign mem_val = mem_q;
`else
    logic unused_mem;

    assign unused_mem = mem_save | mem_recall;
    assign mem_val    = '0;
`endif

    // Priority decode (only the highest-priority input acts) and operand register controls.
    always_comb begin
        hi     = clr | eq | op_add | op_sub;
        e_eq   = eq & ~clr;
        e_op   = (op_add | op_sub) & ~eq & ~clr;
`ifdef CALC_MEM_EN
        e_ms   = mem_save & ~hi;
        e_mr   = mem_recall & ~hi;
        e_key  = key_valid & ~hi & ~mem_save & ~mem_recall;
`else
        e_mr   = 1'b0;
        e_key  = key_valid & ~hi;
`endif
        in_a    = state_q == S_A;
        in_b    = state_q == S_B;
        in_res  = state_q == S_RES;
        a_shift = in_a & e_key;
        b_shift = in_b & e_key;
        a_load  = (in_a & e_mr) | (in_res & (e_op | e_key));
        a_val   = in_res ? (e_op ? result_q : W'(key_code)) : mem_val;
        a_cnt   = (in_res & e_key) ? CW'(1) : FULL;
        b_load  = (in_a & e_op) | (in_b & e_mr) | (in_res & (e_op | e_key));
        b_val   = in_b ? mem_val : '0;
        b_cnt   = in_b ? FULL : '0;
    end

    calc_operand_reg #(.W(W), .CW(CW)) u_a (
        .clk        (clk),
        .rst_l      (rst_l),
        .clr_i      (clr),
        .load_i     (a_load),
        .load_val_i (a_val),
        .load_cnt_i (a_cnt),
        .shift_i    (a_shift),
        .key_i      (key_code),
        .val_o      (a)
    );

    calc_operand_reg #(.W(W), .CW(CW)) u_b (
        .clk        (clk),
        .rst_l      (rst_l),
        .clr_i      (clr),
        .load_i     (b_load),
        .load_val_i (b_val),
        .load_cnt_i (b_cnt),
        .shift_i    (b_shift),
        .key_i      (key_code),
        .val_o      (b)
    );

    // Sequencer FSM with registered ALU handshake, result latch and timeout watchdog.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= S_A;
            alu_start_q <= 1'b0;
            alu_op_q    <= OP_ADD;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
            disp_sel_q  <= 1'b0;
            tmo_q       <= '0;
        end else begin
            alu_start_q <= 1'b0;
            if (clr) begin
                state_q    <= S_A;
                result_q   <= '0;
                overflow_q <= 1'b0;
                err_q      <= 1'b0;
                disp_sel_q <= 1'b0;
                tmo_q      <= '0;
            end else begin
                case (state_q)
                    S_A: begin
                        if (e_op) begin
                            alu_op_q <= op_sub ? OP_SUB : OP_ADD;
                            state_q  <= S_B;
                        end
                    end
                    S_B: begin
                        if (e_eq) begin
                            alu_start_q <= 1'b1;
                            tmo_q       <= '0;
                            state_q     <= S_EXEC;
                        end else if (e_op) begin
                            alu_op_q <= op_sub ? OP_SUB : OP_ADD;
                        end
                    end
                    S_EXEC: begin
                        if (alu_done) begin
                            result_q   <= alu_q;
                            overflow_q <= alu_ovf;
                            disp_sel_q <= 1'b1;
                            state_q    <= S_RES;
                        end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    S_RES: begin
                        if (e_op) begin
                            alu_op_q   <= op_sub ? OP_SUB : OP_ADD;
                            disp_sel_q <= 1'b0;
                            state_q    <= S_B;
                        end else if (e_key) begin
                            overflow_q <= 1'b0;
                            disp_sel_q <= 1'b0;
                            state_q    <= S_A;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign alu_start = alu_start_q;
    assign alu_op    = alu_op_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign disp_sel  = disp_sel_q;
    assign err       = err_q;
    assign state     = state_q;

endmodule
